fifo_drain_ctrl: RTL and testbench

Read-side consumer of the synchronous FIFO. It pulls words out of the FIFO in bursts and presents them on a valid/ready output stream with `m_last` framing. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so no word is lost or duplicated under downstream backpressure. It sits directly downstream of the FIFO: its `fifo_*` inputs connect to the FIFO's `data_out`, `empty`, `almostempty`, `almostfull` and `underflow` outputs, and its `fifo_rd_en` output drives the FIFO's `rd_en`.

---
 rtl/shared_pkg.sv | 22 ++
 rtl/drain_skid_buf.sv | 81 ++++++++
 rtl/fifo_drain_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types for the FIFO drain controller: FSM states, skid entry layout
// and skid sizing constants.
package shared_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // Skid entry at the default 16-bit word width; the skid module builds the
    // same {data, last} layout at its own configured width.
    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } skid_entry_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry skid buffer of {data, last} words. Absorbs the FIFO read latency
// so the drain controller never loses or duplicates a word under backpressure.
// tag_tail_i marks the most recently written entry as the end of its burst.
module drain_skid_buf
    import shared_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [W-1:0]          push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    input  logic                  tag_tail_i,
    output logic [W-1:0]          head_data_o,
    output logic                  head_last_o,
    output logic [SKID_CNT_W-1:0] cnt_o
);

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } entry_t;

    entry_t                mem_q [SKID_DEPTH];
    entry_t                mem_d [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy; push+pop keeps the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (tag_tail_i) begin
            mem_d[wr_ptr_q - 1'b1].last = 1'b1;
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{data: push_data_i, last: push_last_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Register storage and pointers; reset empties the skid and zeroes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q].data;
    assign head_last_o = mem_q[rd_ptr_q].last;
    assign cnt_o       = cnt_q;

    // The read credit in the controller guarantees a full skid is never written
    // unless the head leaves on the same edge.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (cnt_q == SKID_CNT_W'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the synchronous FIFO. Pulls bursts of up to
// BURST_LEN words and presents them as a valid/ready stream framed by m_last.
// Optional macro DRAIN_TIMEOUT_EN: when defined, a FIFO left non-empty for
// TIMEOUT idle cycles starts a partial burst; when undefined, bursts start
// only on fifo_almostfull or flush.
module fifo_drain_ctrl
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    input  logic                  fifo_almostfull,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  underflow_err
);

    if (BURST_LEN < 2 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("fifo_drain_ctrl: BURST_LEN must be 2..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fifo_drain_ctrl: TIMEOUT must be 1..255");
    end

    drain_state_e          state_q, state_d;
    logic [7:0]            rd_cnt_q, rd_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  underflow_err_q, underflow_err_d;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic [SKID_CNT_W:0]   occ;
    logic                  head_last;
    logic                  pop;
    logic                  rd_tag_last;
    logic                  retag_inflight;
    logic                  tag_tail;
    logic                  tmo_expire;

`ifdef DRAIN_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Count idle cycles with data waiting; anything else clears the count.
    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_q == IDLE && !fifo_empty) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    // Register the idle-with-data cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_expire = (state_q == IDLE) && !fifo_empty && (tmo_cnt_q == 8'(TIMEOUT - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    // Read credit, burst tagging and FSM next-state. The credit subtracts a word
    // leaving the skid this cycle so a steady m_ready sustains one read per cycle
    // while a stalled stream still caps skid plus in-flight words at two.
    always_comb begin
        pop             = m_valid && m_ready;
        occ             = {1'b0, skid_cnt} + {{SKID_CNT_W{1'b0}}, inflight_q}
                          - {{SKID_CNT_W{1'b0}}, pop};
        fifo_rd_en      = (state_q == READ) && !fifo_empty && (occ < 3'd2);
        rd_tag_last     = fifo_rd_en &&
                          ((({1'b0, rd_cnt_q} + 9'd1) == 9'(BURST_LEN)) || fifo_almostempty);
        state_d         = state_q;
        rd_cnt_d        = rd_cnt_q;
        inflight_d      = fifo_rd_en;
        inflight_last_d = rd_tag_last;
        retag_inflight  = 1'b0;
        tag_tail        = 1'b0;
        underflow_err_d = underflow_err_q | fifo_underflow;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (fifo_almostfull || flush || tmo_expire)) begin
                    state_d  = READ;
                    rd_cnt_d = 8'd0;
                end
            end
            READ: begin
                if (fifo_rd_en) begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                    if (rd_tag_last) begin
                        state_d = DRAIN;
                    end
                end else if (fifo_empty && rd_cnt_q != 8'd0) begin
                    // FIFO ran dry mid-burst: the newest fetched word closes it.
                    if (inflight_q) begin
                        retag_inflight = 1'b1;
                        state_d        = DRAIN;
                    end else if (skid_cnt > {{(SKID_CNT_W-1){1'b0}}, pop}) begin
                        tag_tail = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and read-tracking registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_cnt_q        <= 8'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    drain_skid_buf #(
        .W (FIFO_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .push_last_i (inflight_last_q | retag_inflight),
        .pop_i       (pop),
        .tag_tail_i  (tag_tail),
        .head_data_o (m_data),
        .head_last_o (head_last),
        .cnt_o       (skid_cnt)
    );

    assign m_valid       = (skid_cnt != '0);
    assign m_last        = m_valid && head_last;
    assign busy          = (state_q != IDLE);
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural one-cycle-latency FIFO.
module tb_fifo_drain_ctrl;
    import shared_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] fifo_dout = 16'h0;
    logic        fifo_empty, fifo_almostempty, fifo_almostfull;
    logic        fifo_underflow = 1'b0;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic [15:0] m_data;
    logic        m_valid, m_ready = 1'b0, m_last, busy, underflow_err;

    // FIFO model
    logic [15:0] fmem [64];
    logic [7:0]  wp = 8'd0, rp = 8'd0;
    logic [7:0]  fcount;
    logic        wr_en = 1'b0, fclr = 1'b0;
    logic [15:0] wr_data = 16'h0;

    int n_checks = 0, n_errors = 0;
    int cyc_n = 0, rd_pulses = 0, first_rd = -1;
    logic [15:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];
    skid_entry_t exp_q[$];
    logic        stall_pend = 1'b0, stall_last = 1'b0;
    logic [15:0] stall_data = 16'h0;
    int          t0;

    fifo_drain_ctrl #(.FIFO_WIDTH(16), .BURST_LEN(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_almostempty(fifo_almostempty), .fifo_almostfull(fifo_almostfull),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    assign fcount           = wp - rp;
    assign fifo_empty       = (fcount == 8'd0);
    assign fifo_almostempty = (fcount == 8'd1);
    assign fifo_almostfull  = (fcount >= 8'd7);

    always @(posedge clk) begin
        if (fclr) begin
            rp <= wp;
        end else if (fifo_rd_en && (wp != rp)) begin
            fifo_dout <= fmem[rp[5:0]];
            rp <= rp + 8'd1;
        end
        if (wr_en) begin
            fmem[wp[5:0]] <= wr_data;
            wp <= wp + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs in the low phase, sample 1ns later.
    task automatic cyc(input logic rdy, input logic fl, input logic we, input logic [15:0] wd);
        @(negedge clk);
        m_ready = rdy; flush = fl; wr_en = we; wr_data = wd;
        #1;
        if (stall_pend)
            check("stall_hold", {14'b0, m_valid, m_last, m_data}, {14'b0, 1'b1, stall_last, stall_data});
        stall_pend = m_valid && !m_ready;
        stall_data = m_data;
        stall_last = m_last;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data); got_l.push_back(m_last); got_c.push_back(cyc_n);
        end
        if (fifo_rd_en) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc_n;
        end
        cyc_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; fclr = 1'b1; m_ready = 1'b0; flush = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        fclr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stall_pend = 1'b0;
    endtask

    task automatic clear_obs();
        got_d.delete(); got_l.delete(); got_c.delete(); exp_q.delete();
        rd_pulses = 0; first_rd = -1;
    endtask

    task automatic preload(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, base + 16'(i));
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // pattern 0: m_ready always 1; pattern 1: 1,0,0 repeating
    task automatic run_until(input int n, input int max_cyc, input int pattern);
        for (int i = 1; i < max_cyc && got_d.size() < n; i++)
            cyc((pattern == 0) ? 1'b1 : ((i % 3) == 0), 1'b0, 1'b0, 16'h0);
    endtask

    task automatic set_exp(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{data: base + 16'(i), last: (i == n - 1)});
    endtask

    task automatic check_burst(input string tag);
        check({tag, "_n"}, 32'(got_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            check({tag, "_d"}, 32'(got_d[i]), 32'(exp_q[i].data));
            check({tag, "_l"}, 32'(got_l[i]), 32'(exp_q[i].last));
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_uferr", 32'(underflow_err), 32'd0);
        do_reset();

        // Flush, full burst
        clear_obs();
        preload(16'h11, 6);
        clear_obs();
        t0 = cyc_n;
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        run_until(4, 40, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        set_exp(16'h11, 4);
        check_burst("full");
        check("full_first_rd", 32'(first_rd), 32'(t0 + 1));
        for (int i = 0; i < got_c.size(); i++)
            check("full_consec", 32'(got_c[i]), 32'(t0 + 3 + i));
        check("full_busy", 32'(busy), 32'd0);
        check("full_remain", 32'(fcount), 32'd2);
        check("full_rd_pulses", 32'(rd_pulses), 32'd4);

        // Short burst
        do_reset();
        preload(16'h21, 2);
        clear_obs();
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        run_until(2, 30, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        set_exp(16'h21, 2);
        check_burst("short");
        check("short_rd_pulses", 32'(rd_pulses), 32'd2);
        check("short_busy", 32'(busy), 32'd0);
        check("short_remain", 32'(fcount), 32'd0);

        // Backpressure
        do_reset();
        preload(16'h31, 6);
        clear_obs();
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        run_until(4, 60, 1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        set_exp(16'h31, 4);
        check_burst("bp");
        check("bp_rd_pulses", 32'(rd_pulses), 32'd4);
        check("bp_remain", 32'(fcount), 32'd2);
        check("bp_busy", 32'(busy), 32'd0);

        // Timeout
        do_reset();
        clear_obs();
        t0 = cyc_n;
        cyc(1'b1, 1'b0, 1'b1, 16'h41);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0);
`ifdef DRAIN_TIMEOUT_EN
        check("tmo_first_rd", 32'(first_rd), 32'(t0 + 17));
        set_exp(16'h41, 1);
        check_burst("tmo");
`else
        check("tmo_no_rd", 32'(rd_pulses), 32'd0);
        check("tmo_no_xfer", 32'(got_d.size()), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        run_until(1, 30, 0);
        set_exp(16'h41, 1);
        check_burst("tmo_flush");
`endif

        // Reset mid-operation
        do_reset();
        preload(16'h51, 6);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_valid", 32'(m_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_data", 32'(m_data), 32'd0);
        check("arst_last", 32'(m_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_pend = 1'b0;
        clear_obs();
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        run_until(4, 40, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        set_exp(16'h53, 4);
        check_burst("resume");
        check("resume_rd_pulses", 32'(rd_pulses), 32'd4);
        check("resume_remain", 32'(fcount), 32'd0);

        // Underflow checker
        @(negedge clk);
        fifo_underflow = 1'b1;
        #1 check("uf_before_edge", 32'(underflow_err), 32'd0);
        @(negedge clk);
        fifo_underflow = 1'b0;
        #1 check("uf_set", 32'(underflow_err), 32'd1);
        repeat (3) @(negedge clk);
        #1 check("uf_sticky", 32'(underflow_err), 32'd1);
        rst_n = 1'b0;
        #1 check("uf_reset", 32'(underflow_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
